// File: rtl/spi_slave_if.sv
// Bus bundle for spi_slave: SPI pins plus the parallel transmit/receive handshake.
interface spi_slave_if #(
  parameter int SIZE = 40
);
  logic            sclk_in;
  logic            cs_n_in;
  logic            mosi_in;
  logic            miso_out;
  logic [SIZE-1:0] tx_data_in;
  logic            tx_load_in;
  logic            tx_ready_out;
  logic [SIZE-1:0] rx_data_out;
  logic            rx_valid_out;
  logic            frame_error_out;

  modport slave (
    input  sclk_in, cs_n_in, mosi_in, tx_data_in, tx_load_in,
    output miso_out, tx_ready_out, rx_data_out, rx_valid_out, frame_error_out
  );

  modport master (
    output sclk_in, cs_n_in, mosi_in, tx_data_in, tx_load_in,
    input  miso_out, tx_ready_out, rx_data_out, rx_valid_out, frame_error_out
  );
endinterface

// File: rtl/spi_slave.sv
// Mode-3 SPI target, oversampled by clk_in, fixed SIZE-bit frames with length checking.
// Optional macro SPI_SLAVE_MISO_HIZ_EN tristates miso_out in IDLE and during reset.
module spi_slave #(
  parameter int SIZE = 40
) (
  input  logic       clk_in,
  input  logic       reset_n_in,
  spi_slave_if.slave bus
);
  localparam int            CW       = $clog2(SIZE + 2);
  localparam logic [CW-1:0] CNT_SIZE = CW'(SIZE);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SIZE + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state_reg, state_next;

  logic [2:0]      sclk_sync_reg;
  logic [2:0]      cs_sync_reg;
  logic [1:0]      mosi_sync_reg;
  logic            sync_live_reg;
  logic            armed_reg;
  logic [SIZE-1:0] tx_buf_reg;
  logic [SIZE-1:0] shift_tx_reg;
  logic [SIZE-1:0] shift_rx_reg;
  logic [SIZE-1:0] rx_data_reg;
  logic [CW-1:0]   bit_cnt_reg;
  logic            miso_reg;
  logic            rx_valid_reg;
  logic            frame_error_reg;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
  assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];
  assign cs_rise   = cs_sync_reg[1] & ~cs_sync_reg[2];
  // A frame may only open once cs_n has been genuinely seen high after reset.
  assign cs_fall   = ~cs_sync_reg[1] & cs_sync_reg[2] & armed_reg;

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      sclk_sync_reg <= 3'b111;
      cs_sync_reg   <= 3'b111;
      mosi_sync_reg <= 2'b00;
      sync_live_reg <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[1:0], bus.sclk_in};
      cs_sync_reg   <= {cs_sync_reg[1:0], bus.cs_n_in};
      mosi_sync_reg <= {mosi_sync_reg[0], bus.mosi_in};
      sync_live_reg <= 1'b1;
      armed_reg     <= armed_reg | (sync_live_reg & cs_sync_reg[0]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) state_reg <= IDLE;
    else             state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cs_fall) state_next = ACTIVE;
      ACTIVE:  if (cs_rise) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      tx_buf_reg      <= '0;
      shift_tx_reg    <= '0;
      shift_rx_reg    <= '0;
      rx_data_reg     <= '0;
      bit_cnt_reg     <= '0;
      miso_reg        <= 1'b0;
      rx_valid_reg    <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      rx_valid_reg    <= 1'b0;
      frame_error_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.tx_load_in) tx_buf_reg <= bus.tx_data_in;
          if (cs_fall) begin
            shift_tx_reg <= tx_buf_reg;
            shift_rx_reg <= '0;
            bit_cnt_reg  <= '0;
            miso_reg     <= tx_buf_reg[SIZE-1];
          end
        end
        ACTIVE: begin
          // A cs_n rise masks any sclk edge detected in the same cycle.
          if (!cs_rise) begin
            if (sclk_rise) begin
              if (bit_cnt_reg < CNT_SIZE)
                shift_rx_reg <= {shift_rx_reg[SIZE-2:0], mosi_sync_reg[1]};
              if (bit_cnt_reg != CNT_MAX)
                bit_cnt_reg <= bit_cnt_reg + CW'(1);
            end
            // The leading falling edge precedes bit 1, whose MSB is already on miso.
            if (sclk_fall && bit_cnt_reg != '0) begin
              shift_tx_reg <= {shift_tx_reg[SIZE-2:0], 1'b0};
              miso_reg     <= shift_tx_reg[SIZE-2];
            end
          end
        end
        DONE: begin
          miso_reg <= 1'b0;
          if (bit_cnt_reg == CNT_SIZE) begin
            rx_data_reg  <= shift_rx_reg;
            rx_valid_reg <= 1'b1;
          end else begin
            frame_error_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_ready_out    = (state_reg == IDLE);
  assign bus.rx_data_out     = rx_data_reg;
  assign bus.rx_valid_out    = rx_valid_reg;
  assign bus.frame_error_out = frame_error_reg;

`ifdef SPI_SLAVE_MISO_HIZ_EN
  assign bus.miso_out = (!reset_n_in || state_reg == IDLE) ? 1'bz : miso_reg;
`else
  assign bus.miso_out = miso_reg;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed vector table, reset corner cases, random frames.
module tb_spi_slave;
  localparam int SIZE = 40;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  spi_slave_if #(.SIZE(SIZE)) bus ();

  spi_slave #(.SIZE(SIZE)) dut (
    .clk_in     (clk),
    .reset_n_in (reset_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int pulse_cyc = 0;
  int rise_cyc = 0;
  logic [63:0] miso_cap;
  logic idle_miso;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_valid_out) begin valid_cnt++; pulse_cyc = cyc; end
    if (bus.frame_error_out) begin err_cnt++; pulse_cyc = cyc; end
    if (bus.rx_valid_out && bus.frame_error_out) both_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [SIZE-1:0] d);
    @(negedge clk);
    check("tx_ready_idle", 64'(bus.tx_ready_out), 64'd1);
    bus.tx_data_in = d;
    bus.tx_load_in = 1'b1;
    @(negedge clk);
    bus.tx_load_in = 1'b0;
  endtask

  // One SPI clock: falling edge drives mosi, miso is taken just before the rising edge.
  task automatic clock_bit(input logic b, input bit do_load, input logic [SIZE-1:0] d);
    bus.sclk_in = 1'b0;
    bus.mosi_in = b;
    if (do_load) begin
      bus.tx_data_in = d;
      bus.tx_load_in = 1'b1;
      @(negedge clk);
      check("tx_ready_active", 64'(bus.tx_ready_out), 64'd0);
      bus.tx_load_in = 1'b0;
      repeat (3) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    miso_cap = {miso_cap[62:0], bus.miso_out};
    bus.sclk_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input int n, input logic [SIZE-1:0] mosi, input bit mid_load,
                           input logic [SIZE-1:0] mid_data);
    logic b;
    miso_cap = '0;
    @(negedge clk);
    bus.cs_n_in = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      b = (i < SIZE) ? mosi[SIZE-1-i] : 1'($urandom);
      clock_bit(b, mid_load && i == 10, mid_data);
    end
    repeat (4) @(negedge clk);
    bus.cs_n_in = 1'b1;
    rise_cyc = cyc;
    repeat (12) @(negedge clk);
  endtask

  typedef struct {
    int             nbits;
    bit             pre_load;
    logic [SIZE-1:0] pre_data;
    bit             mid_load;
    logic [SIZE-1:0] mid_data;
    logic [SIZE-1:0] mosi;
    bit             exp_valid;
    bit             exp_err;
    logic [SIZE-1:0] exp_rx;
    logic [63:0]    exp_miso;
  } vec_t;

  vec_t vecs[6];

  // Reference model state: the word the slave will return, the last good frame.
  logic [SIZE-1:0] tx_model;
  logic [SIZE-1:0] rx_model;

  function automatic logic [63:0] model_miso(input int n, input logic [SIZE-1:0] w);
    logic [63:0] e = '0;
    for (int i = 0; i < n; i++)
      e = {e[62:0], (i < SIZE) ? w[SIZE-1-i] : 1'b0};
    return e;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, e0, n;
    logic [SIZE-1:0] w, m;
    logic [63:0] exp_m;

`ifdef SPI_SLAVE_MISO_HIZ_EN
    idle_miso = 1'bz;
`else
    idle_miso = 1'b0;
`endif

    vecs[0] = '{40, 1, 40'hA50F0FF00F, 0, '0, 40'h123456789A, 1, 0, 40'h123456789A, 64'hA50F0FF00F};
    vecs[1] = '{39, 0, '0, 0, '0, 40'h5555555555, 0, 1, 40'h123456789A, 64'h528787F807};
    vecs[2] = '{41, 0, '0, 0, '0, 40'h3333333333, 0, 1, 40'h123456789A, 64'h14A1E1FE01E};
    vecs[3] = '{40, 0, '0, 1, 40'h1111111111, 40'hCAFEBABE01, 1, 0, 40'hCAFEBABE01, 64'hA50F0FF00F};
    vecs[4] = '{40, 0, '0, 0, '0, 40'h0000000001, 1, 0, 40'h0000000001, 64'hA50F0FF00F};
    vecs[5] = '{40, 1, 40'h00000000FF, 0, '0, 40'hFFFFFFFFFF, 1, 0, 40'hFFFFFFFFFF, 64'h00000000FF};

    bus.sclk_in = 1'b1;
    bus.cs_n_in = 1'b1;
    bus.mosi_in = 1'b0;
    bus.tx_data_in = '0;
    bus.tx_load_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx_ready", 64'(bus.tx_ready_out), 64'd1);
    check("reset_rx_data", 64'(bus.rx_data_out), 64'd0);
    check("reset_pulses", 64'({bus.rx_valid_out, bus.frame_error_out}), 64'd0);
    check("reset_miso", 64'(bus.miso_out), 64'(idle_miso));
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_miso", 64'(bus.miso_out), 64'(idle_miso));

    // Directed vector table.
    for (int k = 0; k < 6; k++) begin
      if (vecs[k].pre_load) load_word(vecs[k].pre_data);
      v0 = valid_cnt; e0 = err_cnt;
      run_frame(vecs[k].nbits, vecs[k].mosi, vecs[k].mid_load, vecs[k].mid_data);
      $display("vec %0d n=%0d mosi=%h rx=%h miso=%h", k, vecs[k].nbits, vecs[k].mosi,
               bus.rx_data_out, miso_cap);
      check("vec_valid", 64'(valid_cnt - v0), 64'(vecs[k].exp_valid));
      check("vec_error", 64'(err_cnt - e0), 64'(vecs[k].exp_err));
      check("vec_rx", 64'(bus.rx_data_out), 64'(vecs[k].exp_rx));
      check("vec_miso", miso_cap, vecs[k].exp_miso);
      check("vec_latency", 64'((pulse_cyc - rise_cyc >= 3) && (pulse_cyc - rise_cyc <= 5)), 64'd1);
      check("vec_idle_miso", 64'(bus.miso_out), 64'(idle_miso));
    end
    tx_model = 40'h00000000FF;
    rx_model = 40'hFFFFFFFFFF;

    // Reset at bit 20 with cs_n held low; the rest of that frame must be ignored.
    load_word(40'h0123456789);
    v0 = valid_cnt; e0 = err_cnt;
    miso_cap = '0;
    @(negedge clk);
    bus.cs_n_in = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 20; i++) clock_bit(1'($urandom), 1'b0, '0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tx_model = '0;
    rx_model = '0;
    check("midreset_rx", 64'(bus.rx_data_out), 64'(rx_model));
    for (int i = 0; i < 20; i++) clock_bit(1'($urandom), 1'b0, '0);
    check("midreset_not_active", 64'(bus.tx_ready_out), 64'd1);
    bus.cs_n_in = 1'b1;
    repeat (12) @(negedge clk);
    $display("midreset frame valid=%0d error=%0d", valid_cnt - v0, err_cnt - e0);
    check("midreset_pulses", 64'((valid_cnt - v0) + (err_cnt - e0)), 64'd0);
    v0 = valid_cnt;
    run_frame(SIZE, 40'h0F1E2D3C4B, 1'b0, '0);
    rx_model = 40'h0F1E2D3C4B;
    $display("postreset frame rx=%h miso=%h", bus.rx_data_out, miso_cap);
    check("postreset_valid", 64'(valid_cnt - v0), 64'd1);
    check("postreset_rx", 64'(bus.rx_data_out), 64'(rx_model));
    check("postreset_miso", miso_cap, model_miso(SIZE, tx_model));

    // Random frames against the model.
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        w = SIZE'({$urandom, $urandom});
        load_word(w);
        tx_model = w;
      end
      n = ($urandom_range(0, 2) == 0) ? SIZE - 2 + int'($urandom_range(0, 4)) : SIZE;
      m = SIZE'({$urandom, $urandom});
      exp_m = model_miso(n, tx_model);
      if (n == SIZE) rx_model = m;
      v0 = valid_cnt; e0 = err_cnt;
      run_frame(n, m, 1'b0, '0);
      $display("rand %0d n=%0d mosi=%h rx=%h miso=%h", k, n, m, bus.rx_data_out, miso_cap);
      check("rand_valid", 64'(valid_cnt - v0), 64'(n == SIZE));
      check("rand_error", 64'(err_cnt - e0), 64'(n != SIZE));
      check("rand_rx", 64'(bus.rx_data_out), 64'(rx_model));
      check("rand_miso", miso_cap, exp_m);
    end

    check("never_both", 64'(both_cnt), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
